// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
package inst_fetch_pkg;

   localparam int unsigned FETCH_DATA_W   = 20;
   localparam int unsigned FETCH_ADDR_W   = 5;
   localparam int unsigned FETCH_DEPTH    = 2;
   localparam int unsigned FETCH_RESET_PC = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with flush; head reads as zero when empty.
// Push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int unsigned WIDTH = FETCH_ADDR_W + FETCH_DATA_W,
   parameter int unsigned DEPTH = FETCH_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     head_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign head_valid = (count != '0);
   assign do_pop     = pop & head_valid;
   // When full, the write lands in the slot being popped this cycle.
   assign do_push    = push & ((count < FULL) | do_pop);
   assign head       = head_valid ? store[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (do_push) begin
         store[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, memory read port, 1-cycle return capture and valid/ready buffer to decode.
// Define FETCH_PERF_EN to add saturating perf_fetched / perf_stall counters.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned DATA_W     = FETCH_DATA_W,
   parameter int unsigned ADDR_W     = FETCH_ADDR_W,
   parameter int unsigned FIFO_DEPTH = FETCH_DEPTH,
   parameter int unsigned RESET_PC   = FETCH_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_pc,
   input  logic              halt_req,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_enable,
   output logic              mem_read_writenot,
   output logic [ADDR_W-1:0] mem_read_address,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   output logic              busy
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       perf_fetched,
   output logic [15:0]       perf_stall
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   fetch_state_t             state;
   logic [ADDR_W-1:0]        pc;
   logic [ADDR_W-1:0]        inflight_pc;
   logic                     inflight;

   logic                     active;
   logic                     issue;
   logic                     push;
   logic                     pop;
   logic                     flush;
   logic [CW-1:0]            occupancy;

   logic [CW-1:0]            fifo_count;
   logic                     fifo_valid;
   logic [ADDR_W+DATA_W-1:0] fifo_head;

   assign active    = (state == RUN) || (state == DRAIN);
   assign pop       = fifo_valid & inst_ready;
   assign flush     = redirect_valid & active;
   assign push      = inflight & ~redirect_valid;

   // Entries the FIFO will hold after this cycle, counting the return now arriving.
   assign occupancy = fifo_count + CW'(inflight) - CW'(pop);
   assign issue     = (state == RUN) & (occupancy < DEPTH_C) & ~redirect_valid & ~halt_req;

   assign mem_enable        = issue;
   assign mem_read_writenot = 1'b1;
   assign mem_read_address  = pc;

   assign inst_valid           = fifo_valid;
   assign {inst_pc, inst_data} = fifo_head;
   assign busy                 = active | inflight;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= ADDR_W'(RESET_PC);
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
            pc          <= pc + 1'b1;
         end
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  state <= RUN;
                  pc    <= start_pc;
               end
            end
            RUN: begin
               if (redirect_valid) begin
                  pc <= redirect_pc;
               end else if (halt_req) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (redirect_valid) begin
                  pc <= redirect_pc;
               end
               if (!inflight) begin
                  state <= HALT;
               end
            end
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push       (push),
      .push_data  ({inflight_pc, mem_rdata}),
      .pop        (pop),
      .head       (fifo_head),
      .head_valid (fifo_valid),
      .count      (fifo_count)
   );

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop && (perf_fetched != '1)) begin
            perf_fetched <= perf_fetched + 1'b1;
         end
         if (fifo_valid && !inst_ready && (perf_stall != '1)) begin
            perf_stall <= perf_stall + 1'b1;
         end
      end
   end
`endif

endmodule
